// File: rtl/merge_avlstrm.sv
// Two-input Avalon-ST packet merge: packet-granular round-robin into a single
// registered output slot, with orphan-beat discard and packet/drop counters.
module merge_avlstrm #(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6,
  parameter int CWIDTH = 12
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DWIDTH-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_sop,
  input  logic              in0_eop,
  input  logic [EWIDTH-1:0] in0_empty,
  input  logic [CWIDTH-1:0] in0_channel,
  output logic              in0_ready,
  output logic              in0_almost_full,
  input  logic [DWIDTH-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_sop,
  input  logic              in1_eop,
  input  logic [EWIDTH-1:0] in1_empty,
  input  logic [CWIDTH-1:0] in1_channel,
  output logic              in1_ready,
  output logic              in1_almost_full,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [EWIDTH-1:0] out_empty,
  output logic [CWIDTH-1:0] out_channel,
  input  logic              out_ready,
  input  logic              out_almost_full,
  output logic [31:0]       stats_in0_pkt,
  output logic [31:0]       stats_in1_pkt,
  output logic [31:0]       stats_out_pkt,
  output logic [31:0]       stats_drop
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            r_state, w_nxt;
  logic              r_rr;  // input preferred on the next sop tie
  logic [DWIDTH-1:0] r_data;
  logic              r_valid, r_sop, r_eop;
  logic [EWIDTH-1:0] r_empty;
  logic [CWIDTH-1:0] r_channel;
  logic [31:0]       r_in0_pkt, r_in1_pkt, r_out_pkt, r_drop;

  logic w_free, w_c0, w_c1, w_sel;
  logic w_rdy0, w_rdy1, w_fwd0, w_fwd1, w_orph0, w_orph1;

  assign w_free = !r_valid || out_ready;
  assign w_c0   = in0_valid && in0_sop;
  assign w_c1   = in1_valid && in1_sop;

  always_comb begin
    w_nxt   = r_state;
    w_sel   = 1'b0;
    w_rdy0  = 1'b0;
    w_rdy1  = 1'b0;
    w_fwd0  = 1'b0;
    w_fwd1  = 1'b0;
    w_orph0 = 1'b0;
    w_orph1 = 1'b0;
    case (r_state)
      IDLE: begin
        // Beats without sop here belong to no packet; swallow them regardless of slot.
        w_orph0 = in0_valid && !in0_sop;
        w_orph1 = in1_valid && !in1_sop;
        w_sel   = (w_c0 && w_c1) ? r_rr : w_c1;
        w_fwd0  = w_c0 && !w_sel && w_free;
        w_fwd1  = w_c1 && w_sel && w_free;
        w_rdy0  = w_orph0 || w_fwd0;
        w_rdy1  = w_orph1 || w_fwd1;
        if (w_fwd0 && !in0_eop)      w_nxt = LOCK0;
        else if (w_fwd1 && !in1_eop) w_nxt = LOCK1;
      end
      LOCK0: begin
        w_rdy0 = w_free;
        w_fwd0 = in0_valid && w_free;
        if (w_fwd0 && in0_eop) w_nxt = IDLE;
      end
      LOCK1: begin
        w_rdy1 = w_free;
        w_fwd1 = in1_valid && w_free;
        if (w_fwd1 && in1_eop) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign in0_ready       = w_rdy0 && Rst_n;
  assign in1_ready       = w_rdy1 && Rst_n;
  assign in0_almost_full = out_almost_full;
  assign in1_almost_full = out_almost_full;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_rr      <= 1'b0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_empty   <= '0;
      r_channel <= '0;
      r_in0_pkt <= '0;
      r_in1_pkt <= '0;
      r_out_pkt <= '0;
      r_drop    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_fwd0 && in0_sop)      r_rr <= 1'b1;
      else if (w_fwd1 && in1_sop) r_rr <= 1'b0;

      if (w_fwd0) begin
        r_valid   <= 1'b1;
        r_data    <= in0_data;
        r_sop     <= in0_sop;
        r_eop     <= in0_eop;
        r_empty   <= in0_empty;
        r_channel <= in0_channel;
      end else if (w_fwd1) begin
        r_valid   <= 1'b1;
        r_data    <= in1_data;
        r_sop     <= in1_sop;
        r_eop     <= in1_eop;
        r_empty   <= in1_empty;
        r_channel <= in1_channel;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if ((w_fwd0 || w_orph0) && in0_eop) r_in0_pkt <= r_in0_pkt + 32'd1;
      if ((w_fwd1 || w_orph1) && in1_eop) r_in1_pkt <= r_in1_pkt + 32'd1;
      if (r_valid && out_ready && r_eop)  r_out_pkt <= r_out_pkt + 32'd1;
      r_drop <= r_drop + {31'd0, w_orph0} + {31'd0, w_orph1};
    end
  end

  assign out_data      = r_data;
  assign out_valid     = r_valid;
  assign out_sop       = r_sop;
  assign out_eop       = r_eop;
  assign out_empty     = r_empty;
  assign out_channel   = r_channel;
  assign stats_in0_pkt = r_in0_pkt;
  assign stats_in1_pkt = r_in1_pkt;
  assign stats_out_pkt = r_out_pkt;
  assign stats_drop    = r_drop;
endmodule

// File: tb/tb_merge_avlstrm.sv
// Directed bench for merge_avlstrm: per-cycle vectors with hand-computed
// ready/output expectations plus counter checks.
module tb_merge_avlstrm;
  localparam int DW = 32, EW = 2, CW = 4;

  logic          Clk = 1'b0, Rst_n = 1'b0;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_valid = 0, in0_sop = 0, in0_eop = 0;
  logic          in1_valid = 0, in1_sop = 0, in1_eop = 0;
  logic [EW-1:0] in0_empty = 2'd1, in1_empty = 2'd2;
  logic [CW-1:0] in0_channel = 4'h3, in1_channel = 4'h5;
  logic          in0_ready, in1_ready, in0_almost_full, in1_almost_full;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [EW-1:0] out_empty;
  logic [CW-1:0] out_channel;
  logic          out_ready = 1'b1, out_almost_full = 1'b0;
  logic [31:0]   stats_in0_pkt, stats_in1_pkt, stats_out_pkt, stats_drop;

  int n_chk = 0, n_err = 0;

  merge_avlstrm #(.DWIDTH(DW), .EWIDTH(EW), .CWIDTH(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop), .in0_eop(in0_eop),
    .in0_empty(in0_empty), .in0_channel(in0_channel), .in0_ready(in0_ready),
    .in0_almost_full(in0_almost_full),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop), .in1_eop(in1_eop),
    .in1_empty(in1_empty), .in1_channel(in1_channel), .in1_ready(in1_ready),
    .in1_almost_full(in1_almost_full),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_channel(out_channel), .out_ready(out_ready),
    .out_almost_full(out_almost_full),
    .stats_in0_pkt(stats_in0_pkt), .stats_in1_pkt(stats_in1_pkt),
    .stats_out_pkt(stats_out_pkt), .stats_drop(stats_drop)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive both inputs, check readies, clock, check the output slot.
  task automatic cyc(input string tag,
                     input logic v0, s0, e0, input logic [DW-1:0] d0,
                     input logic v1, s1, e1, input logic [DW-1:0] d1,
                     input logic xr0, xr1, xov, xsop, xeop, input logic [DW-1:0] xd);
    in0_valid = v0; in0_sop = s0; in0_eop = e0; in0_data = d0;
    in1_valid = v1; in1_sop = s1; in1_eop = e1; in1_data = d1;
    #1;
    chk({tag, ".r0"}, in0_ready, xr0);
    chk({tag, ".r1"}, in1_ready, xr1);
    @(posedge Clk); #1;
    chk({tag, ".ov"}, out_valid, xov);
    if (xov) begin
      chk({tag, ".od"}, out_data, xd);
      chk({tag, ".sop"}, out_sop, xsop);
      chk({tag, ".eop"}, out_eop, xeop);
    end
  endtask

  task automatic idle_in;
    in0_valid = 0; in0_sop = 0; in0_eop = 0;
    in1_valid = 0; in1_sop = 0; in1_eop = 0;
  endtask

  task automatic do_reset;
    idle_in();
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  initial begin
    int i0, i1, g;
    // Reset state, with a valid sop presented during reset.
    in0_valid = 1; in0_sop = 1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.r0", in0_ready, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.sop", out_sop, 0);
    chk("rst.od", out_data, 0);
    chk("rst.ch", out_channel, 0);
    chk("rst.st0", stats_in0_pkt, 0);
    chk("rst.drop", stats_drop, 0);
    out_almost_full = 1; #1;
    chk("af0", in0_almost_full, 1);
    chk("af1", in1_almost_full, 1);
    out_almost_full = 0; #1;
    chk("af0n", in0_almost_full, 0);
    idle_in();
    Rst_n = 1;
    @(posedge Clk); #1;

    // 3-beat packet on in0, 1-cycle latency
    cyc("p3.b0", 1,1,0,32'hA0, 0,0,0,0, 1,0, 1,1,0,32'hA0);
    chk("p3.ch", out_channel, 4'h3);
    chk("p3.emp", out_empty, 2'd1);
    cyc("p3.b1", 1,0,0,32'hA1, 0,0,0,0, 1,0, 1,0,0,32'hA1);
    cyc("p3.b2", 1,0,1,32'hA2, 0,0,0,0, 1,0, 1,0,1,32'hA2);
    cyc("p3.id", 0,0,0,0,      0,0,0,0, 0,0, 0,0,0,0);
    chk("p3.st0", stats_in0_pkt, 1);
    chk("p3.sto", stats_out_pkt, 1);

    // Round-robin on simultaneous single-beat packets, from reset pointer
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      g = k % 2;
      cyc("rr", 1,1,1,32'h100 + i0, 1,1,1,32'h200 + i1,
          (g == 0), (g == 1), 1,1,1, g ? 32'h200 + i1 : 32'h100 + i0);
      if (g) i1++; else i0++;
    end
    chk("rr.n0", i0, 4);
    chk("rr.st0", stats_in0_pkt, 4);
    chk("rr.st1", stats_in1_pkt, 4);

    // in1 locked; in0 sop waits until in1 eop is accepted
    cyc("lk.b0", 0,0,0,0,         1,1,0,32'hB0, 0,1, 1,1,0,32'hB0);
    cyc("lk.b1", 1,1,0,32'hC0,    1,0,0,32'hB1, 0,1, 1,0,0,32'hB1);
    cyc("lk.b2", 1,1,0,32'hC0,    1,0,0,32'hB2, 0,1, 1,0,0,32'hB2);
    cyc("lk.b3", 1,1,0,32'hC0,    1,0,1,32'hB3, 0,1, 1,0,1,32'hB3);
    cyc("lk.c0", 1,1,0,32'hC0,    0,0,0,0,      1,0, 1,1,0,32'hC0);
    cyc("lk.c1", 1,0,1,32'hC1,    0,0,0,0,      1,0, 1,0,1,32'hC1);

    // Downstream stall mid-packet: output held, no accept, then full rate
    cyc("st.d0", 1,1,0,32'hD0, 0,0,0,0, 1,0, 1,1,0,32'hD0);
    cyc("st.d1", 1,0,0,32'hD1, 0,0,0,0, 1,0, 1,0,0,32'hD1);
    out_ready = 0;
    for (int k = 0; k < 5; k++)
      cyc("st.hold", 1,0,0,32'hD2, 0,0,0,0, 0,0, 1,0,0,32'hD1);
    out_ready = 1;
    cyc("st.d2", 1,0,0,32'hD2, 0,0,0,0, 1,0, 1,0,0,32'hD2);
    cyc("st.d3", 1,0,1,32'hD3, 0,0,0,0, 1,0, 1,0,1,32'hD3);
    cyc("st.id", 0,0,0,0,      0,0,0,0, 0,0, 0,0,0,0);
    chk("st.sto", stats_out_pkt, 11);
    chk("st.st0", stats_in0_pkt, 6);
    chk("st.st1", stats_in1_pkt, 5);

    // Orphan beat in IDLE
    cyc("or.b", 1,0,0,32'hEE, 0,0,0,0, 1,0, 0,0,0,0);
    chk("or.drop", stats_drop, 1);
    chk("or.sto", stats_out_pkt, 11);

    // Reset mid-packet: remaining beats become orphans
    cyc("rm.e0", 0,0,0,0, 1,1,0,32'hE0, 0,1, 1,1,0,32'hE0);
    cyc("rm.e1", 0,0,0,0, 1,0,0,32'hE1, 0,1, 1,0,0,32'hE1);
    idle_in();
    Rst_n = 0;
    #1;
    chk("rm.ov", out_valid, 0);
    chk("rm.drop0", stats_drop, 0);
    chk("rm.r1", in1_ready, 0);
    Rst_n = 1;
    cyc("rm.e2", 0,0,0,0, 1,0,0,32'hE2, 0,1, 0,0,0,0);
    cyc("rm.e3", 0,0,0,0, 1,0,1,32'hE3, 0,1, 0,0,0,0);
    chk("rm.drop", stats_drop, 2);
    chk("rm.st1", stats_in1_pkt, 1);
    cyc("rm.f0", 1,1,1,32'hF0, 0,0,0,0, 1,0, 1,1,1,32'hF0);
    cyc("rm.id", 0,0,0,0,      0,0,0,0, 0,0, 0,0,0,0);
    chk("rm.sto", stats_out_pkt, 1);
    chk("rm.st0", stats_in0_pkt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/merge_avlstrm.md
MERGE_AVLSTRM -- requirements
Module: merge_avlstrm

Interface
REQ-001 SHALL have parameter DWIDTH, default 512: data beat width in bits.
REQ-002 SHALL have parameter EWIDTH, default 6: empty-field width, log2(DWIDTH/8).
REQ-003 SHALL have parameter CWIDTH, default 12: channel width.
REQ-004 SHALL have port Clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have ports in0_data/in0_valid/in0_sop/in0_eop/in0_empty/in0_channel  input  DWIDTH/1/1/1/EWIDTH/CWIDTH: stream 0 beat.
REQ-007 SHALL have ports in0_ready, in0_almost_full  output  1 each: stream 0 backpressure.
REQ-008 SHALL have port set in1_* identical to REQ-006/007: stream 1.
REQ-009 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty/out_channel  output  same widths: merged stream.
REQ-010 SHALL have ports out_ready, out_almost_full  input  1 each: downstream backpressure.
REQ-011 SHALL have ports stats_in0_pkt, stats_in1_pkt, stats_out_pkt, stats_drop  output  32 each: counters.

Function
REQ-012 SHALL merge in0 and in1 into out with packet-granular arbitration; beats of different packets never interleave on out.
REQ-013 SHALL use FSM states IDLE, LOCK0, LOCK1.
REQ-014 SHALL hold one output register slot; slot is free when !out_valid or out_ready.
REQ-015 SHALL assert inN_ready only when the slot is free and inN is the selected source (IDLE) or locked source (LOCKN); the unselected input's ready is 0.
REQ-016 IDLE: candidate = inN with valid && sop; both candidates -> grant the input not granted last (rr pointer); reset pointer prefers in0.
REQ-017 IDLE: the granted sop beat transfers the same cycle if the slot is free; without eop the FSM moves to LOCKN; with sop&&eop it stays IDLE; the rr pointer updates on every accepted sop.
REQ-018 LOCKN: beats of inN are accepted while the slot is free; an accepted eop beat returns the FSM to IDLE; the other input waits.
REQ-019 IDLE: a valid beat without sop on either input (orphan) SHALL be accepted (ready=1) and discarded, stats_drop += 1, not forwarded; orphan discard ignores slot state.
REQ-020 LOCKN: a beat with sop on inN (missing eop) SHALL be forwarded as a new packet: the register loads it and the FSM stays LOCKN unless it also carries eop.
REQ-021 SHALL register out_* fields from the accepted beat: latency exactly 1 cycle input-accept to out_valid; out_* stable while out_valid && !out_ready.
REQ-022 SHALL drive in0_almost_full = in1_almost_full = out_almost_full (combinational passthrough).
REQ-023 stats_inN_pkt SHALL +1 per accepted inN eop beat (including orphans); stats_out_pkt +1 per out_valid&&out_ready&&out_eop; all counters wrap 2^32-1 -> 0.
REQ-024 Simultaneous out handshake and new accept SHALL give back-to-back beats with no bubble (full throughput: 1 beat/cycle).

Reset
REQ-025 Rst_n low SHALL immediately force FSM=IDLE, rr pointer=in0, out_valid=0, out_sop=out_eop=0, out_data/empty/channel=0, all stats=0, in0_ready=in1_ready=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; after release, remaining non-sop beats are treated as orphans (REQ-019).

Verification
REQ-027 in0 sends 3-beat packet, out_ready=1 -> out beats at cycles t+1..t+3, sop on first, eop on third, stats_in0_pkt=1, stats_out_pkt=1.
REQ-028 in0 and in1 both present sop same cycle, repeated 4 single-beat packets each -> out order in0,in1,in0,in1,...; no starvation.
REQ-029 in1 locks 4-beat packet; in0 sop arrives at beat 2 -> in0_ready=0 until in1 eop accepted, in0 packet follows with zero interleave.
REQ-030 out_ready low for 5 cycles mid-packet -> out_* held constant, inN_ready=0, no beat lost or duplicated; resume at 1 beat/cycle.
REQ-031 in0 drives valid non-sop beat in IDLE -> beat discarded, stats_drop=1, out_valid stays 0.
REQ-032 Rst_n pulsed low after beat 2 of a 4-beat packet -> out_valid=0 immediately; beats 3-4 counted as drops (stats_drop=2); next sop packet passes normally.
